l2_writeback_buffer: RTL and testbench

Single-entry victim writeback buffer between the L2 4-way cache controller and physical memory. When the controller evicts a dirty 256-bit line out of the L2 data arrays, it hands the line here and continues servicing misses while the buffer drains the line to memory with the pmem write handshake. Address comparison lets the controller detect misses that hit the line still in flight.

---
 rtl/l2_pkg.sv | 12 +
 rtl/l2_writeback_buffer.sv | 82 ++++++++
 tb/tb_l2_writeback_buffer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/l2_pkg.sv
// Shared L2 cache types and line-geometry constants.
package l2_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

  localparam int L2_LINE_OFFSET_BITS = 5;
  localparam int L2_LINE_WIDTH       = 256;

endpackage

// File: rtl/l2_writeback_buffer.sv
// Single-entry dirty-victim writeback buffer draining one L2 line to pmem.
// Define L2_WB_FORWARD_EN to forward the buffered line on lk_data when lk_hit.
module l2_writeback_buffer
  import l2_pkg::*;
#(
  parameter int width      = L2_LINE_WIDTH,
  parameter int addr_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_req,
  input  logic [addr_width-1:0] wb_addr,
  input  logic [width-1:0]      wb_data,
  output logic                  wb_ack,
  output logic                  wb_full,
  input  logic [addr_width-1:0] lk_addr,
  output logic                  lk_hit,
  output logic [width-1:0]      lk_data,
  output logic                  pmem_write,
  output logic [addr_width-1:0] pmem_address,
  output logic [width-1:0]      pmem_wdata,
  input  logic                  pmem_resp
);

  // Clears the byte-offset bits so addresses compare and store line-aligned.
  localparam logic [addr_width-1:0] LINE_MASK =
    {{(addr_width-L2_LINE_OFFSET_BITS){1'b1}}, {L2_LINE_OFFSET_BITS{1'b0}}};

  wb_state_t             state_reg, state_next;
  logic [addr_width-1:0] addr_reg;
  logic [width-1:0]      data_reg;
  logic                  accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wb_ack     = 1'b0;
    case (state_reg)
      EMPTY: begin
        wb_ack = wb_req;
        if (wb_req) state_next = WRITE;
      end
      WRITE: begin
        if (pmem_resp) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  assign accept = (state_reg == EMPTY) && wb_req;

  // Latched line is kept after draining; all outputs below gate on state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
      data_reg <= '0;
    end else if (accept) begin
      addr_reg <= wb_addr & LINE_MASK;
      data_reg <= wb_data;
    end
  end

  assign wb_full      = (state_reg == WRITE);
  assign pmem_write   = wb_full;
  assign pmem_address = wb_full ? addr_reg : '0;
  assign pmem_wdata   = wb_full ? data_reg : '0;
  assign lk_hit       = wb_full && ((lk_addr & LINE_MASK) == addr_reg);

`ifdef L2_WB_FORWARD_EN
  assign lk_data = lk_hit ? data_reg : '0;
`else
  assign lk_data = '0;
`endif

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Self-checking bench for l2_writeback_buffer: directed stimulus plus a write scoreboard.
module tb_l2_writeback_buffer;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_req;
  logic [31:0]  wb_addr;
  logic [255:0] wb_data;
  logic         wb_ack;
  logic         wb_full;
  logic [31:0]  lk_addr;
  logic         lk_hit;
  logic [255:0] lk_data;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  localparam logic [255:0] D_A5 = {32{8'hA5}};
  localparam logic [255:0] D_X1 = {8{32'h1111_2222}};
  localparam logic [255:0] D_X2 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] D_X3 = {8{32'h0F0F_F0F0}};

  l2_writeback_buffer dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
    .wb_full(wb_full), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, " wb_ack"}, 256'(wb_ack), 256'(1'b0));
    chk({tag, " wb_full"}, 256'(wb_full), 256'(1'b0));
    chk({tag, " pmem_write"}, 256'(pmem_write), 256'(1'b0));
    chk({tag, " pmem_address"}, 256'(pmem_address), 256'(32'h0));
    chk({tag, " lk_hit"}, 256'(lk_hit), 256'(1'b0));
  endtask

  // Monitor: every completed pmem write (write && resp) must match the next expected line.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (pmem_write && pmem_resp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected actual=%0h required=none", pmem_address);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 256'(pmem_address), 256'(e.addr));
          chk("wr_data", pmem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    logic [255:0] fwd;
    rst = 1'b1; wb_req = 1'b0; wb_addr = '0; wb_data = '0; lk_addr = '0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 idle_outputs("in_reset");
    chk("in_reset lk_data", lk_data, '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1 idle_outputs("idle");
    chk("idle pmem_wdata", pmem_wdata, '0);

    // First line: accept, drain after 4 cycles of resp low.
    wb_req = 1'b1; wb_addr = 32'h0000_1234; wb_data = D_A5;
    #1 chk("acc1 wb_ack", 256'(wb_ack), 256'(1'b1));
    exp_q.push_back('{addr: 32'h0000_1220, data: D_A5});
    @(negedge clk);
    wb_req = 1'b0;
    #1 chk("w1 pmem_write", 256'(pmem_write), 256'(1'b1));
    chk("w1 wb_full", 256'(wb_full), 256'(1'b1));
    chk("w1 pmem_address", 256'(pmem_address), 256'(32'h0000_1220));
    chk("w1 pmem_wdata", pmem_wdata, D_A5);
    lk_addr = 32'h0000_123C;
`ifdef L2_WB_FORWARD_EN
    fwd = D_A5;
`else
    fwd = '0;
`endif
    #1 chk("lk_same_line hit", 256'(lk_hit), 256'(1'b1));
    chk("lk_same_line data", lk_data, fwd);
    lk_addr = 32'h0000_1240;
    #1 chk("lk_next_line hit", 256'(lk_hit), 256'(1'b0));
    chk("lk_next_line data", lk_data, '0);
    lk_addr = 32'h0000_123C;
    repeat (3) @(negedge clk);
    #1 chk("w1 held pmem_write", 256'(pmem_write), 256'(1'b1));
    chk("w1 held wb_ack", 256'(wb_ack), 256'(1'b0));
    @(negedge clk);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1 chk("d1 wb_full", 256'(wb_full), 256'(1'b0));
    chk("d1 lk_hit", 256'(lk_hit), 256'(1'b0));
    chk("d1 pmem_write", 256'(pmem_write), 256'(1'b0));

    // Second request arriving alongside pmem_resp must wait one cycle.
    wb_req = 1'b1; wb_addr = 32'h0000_2000; wb_data = D_X1;
    #1 chk("acc2 wb_ack", 256'(wb_ack), 256'(1'b1));
    exp_q.push_back('{addr: 32'h0000_2000, data: D_X1});
    @(negedge clk);
    wb_addr = 32'h0000_3004; wb_data = D_X2; pmem_resp = 1'b1;
    #1 chk("resp_cycle wb_ack", 256'(wb_ack), 256'(1'b0));
    @(negedge clk);
    pmem_resp = 1'b0;
    #1 chk("acc3 wb_ack", 256'(wb_ack), 256'(1'b1));
    exp_q.push_back('{addr: 32'h0000_3000, data: D_X2});
    @(negedge clk);
    wb_req = 1'b0;
    #1 chk("w3 pmem_address", 256'(pmem_address), 256'(32'h0000_3000));
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b1;
    #1 chk("resp_in_empty wb_full", 256'(wb_full), 256'(1'b0));
    @(negedge clk);
    pmem_resp = 1'b0;
    #1 chk("after_stray_resp wb_full", 256'(wb_full), 256'(1'b0));

    // Reset two cycles into WRITE discards the line.
    wb_req = 1'b1; wb_addr = 32'h0000_4000; wb_data = D_X3;
    @(negedge clk);
    wb_req = 1'b0;
    @(negedge clk);
    #1 chk("pre_rst pmem_write", 256'(pmem_write), 256'(1'b1));
    rst = 1'b1;
    #1 chk("async_rst pmem_write", 256'(pmem_write), 256'(1'b0));
    chk("async_rst wb_full", 256'(wb_full), 256'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1 idle_outputs("post_rst");

    repeat (2) @(negedge clk);
    chk("scoreboard drained", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
